// File: rtl/fft_out_reorder_if.sv
// Stream bundle for fft_out_reorder: two-lane bit-reversed input side and
// natural-order output side, plus the sticky overflow flag.
interface fft_out_reorder_if #(
  parameter int BW    = 16,
  parameter int LOG2N = 6
);
  logic             in_valid;
  logic [BW-1:0]    inReal0;
  logic [BW-1:0]    inImag0;
  logic [BW-1:0]    inReal1;
  logic [BW-1:0]    inImag1;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [BW-1:0]    outReal;
  logic [BW-1:0]    outImag;
  logic [LOG2N-1:0] out_index;
  logic             out_last;
  logic             overflow;

  modport master (
    output in_valid, inReal0, inImag0, inReal1, inImag1, out_ready,
    input  in_ready, out_valid, outReal, outImag, out_index, out_last, overflow
  );

  modport slave (
    input  in_valid, inReal0, inImag0, inReal1, inImag1, out_ready,
    output in_ready, out_valid, outReal, outImag, out_index, out_last, overflow
  );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: bit-reversed two-lane DIF output in, natural-order
// serial bins out. Pairs are written straight to their bin address.
module fft_out_reorder #(
  parameter int BW    = 16,
  parameter int LOG2N = 6
) (
  input  logic               clk,
  input  logic               nrst,
  fft_out_reorder_if.slave   bus
);
  localparam int N = 1 << LOG2N;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} buf_state_t;

  buf_state_t       st_q [2];
  buf_state_t       st_d [2];
  logic             wsel_q, wsel_d;
  logic             rsel_q, rsel_d;
  logic [LOG2N-2:0] wp_q, wp_d;
  logic [LOG2N-1:0] rp_q, rp_d;
  logic             ovf_q, ovf_d;

  logic [2*BW-1:0]  mem [2][N];
  logic [2*BW-1:0]  rd_word;
  logic [LOG2N-1:0] addr0, addr1;
  logic             in_ready, rd_valid, wr, rd;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int unsigned i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  assign in_ready = (st_q[wsel_q] != FULL);
  assign rd_valid = (st_q[rsel_q] == FULL);
  assign wr       = bus.in_valid & in_ready;
  assign rd       = rd_valid & bus.out_ready;
  assign addr0    = bitrev({wp_q, 1'b0});
  assign addr1    = bitrev({wp_q, 1'b1});

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      wsel_q  <= 1'b0;
      rsel_q  <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      ovf_q   <= ovf_d;
    end
  end

  // A buffer is never written and read in the same cycle (FULL gates both),
  // so the write and read updates below touch disjoint buffer states.
  always_comb begin
    st_d   = st_q;
    wsel_d = wsel_q;
    rsel_d = rsel_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    ovf_d  = ovf_q | (bus.in_valid & ~in_ready);
    if (wr) begin
      if (st_q[wsel_q] == EMPTY) st_d[wsel_q] = FILLING;
      if (wp_q == '1) begin
        st_d[wsel_q] = FULL;
        wp_d         = '0;
        wsel_d       = ~wsel_q;
      end else begin
        wp_d = wp_q + 1'b1;
      end
    end
    if (rd) begin
      if (rp_q == '1) begin
        st_d[rsel_q] = EMPTY;
        rp_d         = '0;
        rsel_d       = ~rsel_q;
      end else begin
        rp_d = rp_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wsel_q][addr0] <= {bus.inReal0, bus.inImag0};
      mem[wsel_q][addr1] <= {bus.inReal1, bus.inImag1};
    end
  end

  // Outputs are masked by rd_valid so reset clears them at once and
  // uninitialised memory is never visible.
  assign rd_word       = mem[rsel_q][rp_q];
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = rd_valid;
  assign bus.outReal   = rd_valid ? rd_word[2*BW-1:BW] : '0;
  assign bus.outImag   = rd_valid ? rd_word[BW-1:0]    : '0;
  assign bus.out_index = rd_valid ? rp_q : '0;
  assign bus.out_last  = rd_valid & (rp_q == '1);
  assign bus.overflow  = ovf_q;
endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 Parameter BW, default 16: width of each real and each imaginary sample component.
REQ-002 Parameter LOG2N, default 6: log2 of the frame length N (N = 64 by default).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, named as follows:
  clk  input  1  single clock; all state changes on its rising edge.
  nrst  input  1  asynchronous, active-low reset.
REQ-004 The remaining ports SHALL be:
  in_valid  input  1  a sample pair is present this cycle.
  inReal0, inImag0  input  BW each  lane-0 sample, two's complement.
  inReal1, inImag1  input  BW each  lane-1 sample, two's complement.
  in_ready  output  1  a write buffer can accept a pair.
  out_valid  output  1  outReal, outImag and out_index hold a valid bin.
  out_ready  input  1  the downstream stage accepts the current bin.
  outReal, outImag  output  BW each  bin value, natural order.
  out_index  output  LOG2N  bin number of the current output.
  out_last  output  1  the current bin is N-1.
  overflow  output  1  sticky: a pair arrived while in_ready was low.

Function
REQ-005 The block SHALL convert the two-lane, bit-reversed radix-2 DIF output stream into a serial, natural-order stream of N bins per frame.
REQ-006 Arrival order: pair p (0..N/2-1) of a frame is the p-th accepted pair; lane L carries sequence position s = 2p+L; the bin number is bitrev_LOG2N(s).
REQ-007 Storage: two frame buffers (A and B), each N words of 2*BW bits; each buffer is in state EMPTY, FILLING or FULL.
REQ-008 Write pointer: selects the buffer being filled and a pair counter wp (0..N/2-1); both lanes of an accepted pair (in_valid & in_ready) SHALL be written in the same cycle.
REQ-009 in_ready SHALL be high exactly when the write-selected buffer is EMPTY or FILLING; it is registered state, not a combinational function of out_ready.
REQ-010 Write-side transitions:
  - first accepted pair: EMPTY -> FILLING.
  - pair with wp = N/2-1: the buffer goes to FULL, wp wraps to 0 and the write select toggles.
REQ-011 Read side: when the read-selected buffer is FULL, out_valid SHALL be high and present bin rp (0..N-1, starting at 0).
REQ-012 Read handshake:
  - out_valid & out_ready: rp increments.
  - out_valid & !out_ready: outReal, outImag, out_index and out_last SHALL hold stable.
  - out_valid SHALL NOT drop until the bin is accepted.
REQ-013 When bin N-1 is accepted, the buffer SHALL go to EMPTY, rp SHALL wrap to 0 and the read select SHALL toggle.
REQ-014 Latency: if the last pair of a frame is accepted in cycle t and the read side is idle, out_valid SHALL be high in cycle t+1 with out_index = 0.
REQ-015 Throughput: one bin per cycle while out_ready is held high; a gapless frame of N bins SHALL take N cycles to drain.
REQ-016 Simultaneous events in one cycle SHALL both take effect:
  - one buffer completes filling while the other releases its last bin; or
  - one buffer is written while the other is read.
REQ-017 Overflow: in_valid while in_ready is low SHALL discard the pair, change no buffer contents or pointers, and set overflow until reset.
REQ-018 Data SHALL pass bit-exact: no scaling, rounding or sign change.
REQ-019 in_valid gaps inside a frame SHALL be allowed; wp advances only on accepted pairs.

Reset
REQ-020 When nrst is low, the block SHALL immediately, without waiting for a clock edge:
  - set both buffers to EMPTY, wp and rp to 0, and both selects to buffer A;
  - clear out_valid, outReal, outImag, out_index, out_last and overflow to 0;
  - set in_ready to 1 once the reset is released.
REQ-021 Reset mid-frame SHALL discard partial and full frames; the first pair after reset is pair 0 of a new frame.
REQ-022 Buffer memory contents need not be cleared; no output SHALL expose them before a frame completes.

Verification
REQ-023 Single frame, N=64: send 32 pairs with lane value = {s, ~s} where s = 2p+L, out_ready=1 -> 64 bins, out_index k carries {bitrev6(k)-source s}, i.e. outReal = bitrev6(k), out_last only at k=63, out_valid first in the cycle after pair 31.
REQ-024 Backpressure: out_ready toggles 1,0,0,1 repeating -> no bin lost or duplicated; outputs stable during every stall cycle.
REQ-025 Ping-pong: three back-to-back frames with out_ready=0 -> in_ready drops after frame 2 (pair 63 total); frame-3 pair 0 sets overflow=1; releasing out_ready drains frames 1 then 2 intact.
REQ-026 Simultaneous: frame 2 completes in the same cycle frame 1 releases bin 63 -> out_valid stays high, next cycle out_index=0 from frame 2, in_ready=1.
REQ-027 Reset mid-operation: assert nrst low after pair 10 of frame 2 while frame 1 is at bin 20 -> out_valid=0 and overflow=0 immediately; a fresh 32-pair frame then drains correctly from bin 0.
REQ-028 Gapped input: in_valid high every third cycle, values -32768 and 32767 -> bit-exact output and correct ordering.
